// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO controller for a single-port RAM with a registered read address.
// Define RAM_FIFO_FLAGS_EN to add registered full/empty/almost_full outputs.
module ram_fifo_ctrl #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
`ifdef RAM_FIFO_FLAGS_EN
    , parameter int AFULL_THRESH = 6
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   count,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
`ifdef RAM_FIFO_FLAGS_EN
    , output logic            full,
    output logic              empty,
    output logic              almost_full
`endif
);
    typedef enum logic {GNT_READ = 1'b0, GNT_WRITE = 1'b1} grant_e;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   ram_cnt, ram_cnt_nxt;
    logic              rd_pend;
    grant_e            last_grant;
    logic              read_req, write_ok, wr_gnt, rd_gnt, out_valid_nxt;

    assign read_req  = (ram_cnt != '0) && !out_valid && !rd_pend;
    assign write_ok  = ram_cnt < DEPTH_C;
    // A read that lost the last tie blocks writes, so ties alternate.
    assign in_ready  = !rst && write_ok && !(read_req && last_grant == GNT_WRITE);
    assign wr_gnt    = in_valid && in_ready;
    assign rd_gnt    = !rst && read_req && !wr_gnt;

    assign ram_wr_en   = wr_gnt;
    assign ram_addr    = wr_gnt ? wr_ptr : rd_ptr;
    assign ram_data_in = in_data;

    always_comb begin
        ram_cnt_nxt = ram_cnt;
        if (wr_gnt)      ram_cnt_nxt = ram_cnt + (ADDR_W+1)'(1);
        else if (rd_gnt) ram_cnt_nxt = ram_cnt - (ADDR_W+1)'(1);
    end

    // Capture and pop never coincide: a read is only issued while out_valid=0.
    assign out_valid_nxt = rd_pend || (out_valid && !out_ready);

    assign count = ram_cnt + (ADDR_W+1)'(rd_pend) + (ADDR_W+1)'(out_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ram_cnt    <= '0;
            rd_pend    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            last_grant <= GNT_READ;
        end else begin
            ram_cnt   <= ram_cnt_nxt;
            rd_pend   <= rd_gnt;
            out_valid <= out_valid_nxt;
            if (wr_gnt) begin
                wr_ptr     <= wr_ptr + ADDR_W'(1);
                last_grant <= GNT_WRITE;
            end else if (rd_gnt) begin
                rd_ptr     <= rd_ptr + ADDR_W'(1);
                last_grant <= GNT_READ;
            end
            if (rd_pend) out_data <= ram_data_out;
        end
    end

`ifdef RAM_FIFO_FLAGS_EN
    localparam logic [ADDR_W:0] FULL_C  = (ADDR_W+1)'(DEPTH + 1);
    localparam logic [ADDR_W:0] AFULL_C = (ADDR_W+1)'(AFULL_THRESH);

    logic [ADDR_W:0] cnt_nxt;
    assign cnt_nxt = ram_cnt_nxt + (ADDR_W+1)'(rd_gnt) + (ADDR_W+1)'(out_valid_nxt);

    always_ff @(posedge clk) begin
        if (rst) begin
            full        <= 1'b0;
            empty       <= 1'b1;
            almost_full <= 1'b0;
        end else begin
            full        <= cnt_nxt == FULL_C;
            empty       <= cnt_nxt == '0;
            almost_full <= cnt_nxt >= AFULL_C;
        end
    end
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: behavioural RAM, queue-based reference model, pop scoreboard.
module tb_ram_fifo_ctrl;
    localparam int DW = 128;
    localparam int AW = 3;
    localparam int D  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, out_valid, ram_wr_en;
    logic [DW-1:0] out_data, ram_data_in, ram_data_out;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr;
`ifdef RAM_FIFO_FLAGS_EN
    logic          full, empty, almost_full;
`endif

    ram_fifo_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count),
        .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
`ifdef RAM_FIFO_FLAGS_EN
        , .full(full), .empty(empty), .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    // 8x128 single-port RAM with registered read address
    logic [DW-1:0] mem [D];
    logic [AW-1:0] addr_q;
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr] <= ram_data_in;
        addr_q <= ram_addr;
    end
    assign ram_data_out = mem[addr_q];

    // Reference model: words in RAM as a queue, plus in-flight and output slots
    logic [DW-1:0] ramq[$];
    logic [DW-1:0] sent[$];
    logic [DW-1:0] popped[$];
    logic [DW-1:0] m_pend_w, m_out;
    bit            m_pend, m_valid, m_last_w;
    int            wcnt, rcnt;
    int            checks, errors;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit iv, input bit ordy, input logic [DW-1:0] d, input bit r,
                        output bit acc);
        bit rreq, wok, ir, wg, rg;
        int cnt;
        in_valid = iv; out_ready = ordy; in_data = d; rst = r;
        #1;
        cnt  = ramq.size() + int'(m_pend) + int'(m_valid);
        rreq = ramq.size() > 0 && !m_valid && !m_pend;
        wok  = ramq.size() < D;
        ir   = !r && wok && !(rreq && m_last_w);
        wg   = iv && ir;
        rg   = !r && rreq && !wg;
        chk("in_ready", in_ready, ir);
        chk("ram_wr_en", ram_wr_en, wg);
        chk("ram_addr", ram_addr, wg ? (wcnt % D) : (rcnt % D));
        chk("ram_data_in", ram_data_in, d);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_out);
        chk("count", count, cnt);
`ifdef RAM_FIFO_FLAGS_EN
        chk("full", full, cnt == D + 1);
        chk("empty", empty, cnt == 0);
        chk("almost_full", almost_full, cnt >= 6);
`endif
        if (!r && m_valid && ordy) begin
            popped.push_back(out_data);
            if (sent.size() > 0) chk("pop_order", out_data, sent.pop_front());
        end
        acc = wg;
        @(posedge clk);
        if (r) begin
            ramq.delete(); sent.delete();
            m_pend = 0; m_valid = 0; m_out = '0; m_last_w = 0;
            wcnt = 0; rcnt = 0;
        end else begin
            if (m_pend) begin
                m_out = m_pend_w; m_valid = 1; m_pend = 0;
            end else if (m_valid && ordy) begin
                m_valid = 0;
            end
            if (wg) begin
                ramq.push_back(d); sent.push_back(d); wcnt++; m_last_w = 1;
            end else if (rg) begin
                m_pend_w = ramq.pop_front(); m_pend = 1; rcnt++; m_last_w = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int v, n;
        checks = 0; errors = 0;
        m_pend = 0; m_valid = 0; m_last_w = 0; m_out = '0; m_pend_w = '0;
        wcnt = 0; rcnt = 0;

        // Bring the DUT out of X before comparing anything
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles with a pushing producer
        step(1, 0, '1, 1, acc);
        step(1, 0, '1, 1, acc);

        // Single word: write, read next cycle, valid after the second edge
        step(1, 1, {16{8'hA5}}, 0, acc);
        for (int i = 0; i < 5; i++) step(0, 1, '0, 0, acc);
        chk("single_count_end", count, 0);

        // Fill with the consumer stalled: 9 of 10 offered words fit
        v = 1;
        for (int i = 0; i < 30; i++) begin
            step(1, 0, 128'(v), 0, acc);
            if (acc && v < 10) v++;
        end
        chk("fill_count", count, 9);
        chk("fill_in_ready", in_ready, 0);
        popped.delete();
        for (int i = 0; i < 30; i++) step(0, 1, '0, 0, acc);
        chk("fill_pops", popped.size(), 9);
        for (int i = 0; i < popped.size() && i < 9; i++) chk("fill_word", popped[i], 128'(i + 1));

        // Contention: producer and consumer both always ready
        for (int i = 0; i < 50; i++)
            step(1, 1, {$urandom, $urandom, $urandom, $urandom}, 0, acc);
        for (int i = 0; i < 25; i++) step(0, 1, '0, 0, acc);
        chk("contention_drained", count, 0);

        // Wrap-around: 0..19 with random producer/consumer gaps
        popped.delete();
        v = 0;
        for (int i = 0; i < 400 && popped.size() < 20; i++) begin
            step(v < 20 && ($urandom % 4) != 0, ($urandom % 2) == 1, 128'(v), 0, acc);
            if (acc) v++;
        end
        chk("wrap_pops", popped.size(), 20);
        for (int i = 0; i < popped.size() && i < 20; i++) chk("wrap_word", popped[i], 128'(i));

        // Reset mid-operation with five words held
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            step(1, 0, 128'(100 + n), 0, acc);
            if (acc) n++;
        end
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, acc);
        chk("mid_count_before", count, 5);
        step(0, 0, '0, 1, acc);
        chk("mid_count_after", count, 0);
        chk("mid_valid_after", out_valid, 0);
        popped.delete();
        step(1, 1, 128'h1234, 0, acc);
        for (int i = 0; i < 10 && popped.size() == 0; i++) step(0, 1, '0, 0, acc);
        chk("mid_pop_seen", popped.size() > 0, 1);
        if (popped.size() > 0) chk("mid_first_word", popped[0], 128'h1234);
        step(0, 1, '0, 0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
